fare_ctrl: RTL and testbench

Payment-side controller for the ticket vending machine. It accumulates coin credit and, once credit reaches the fare, starts the ticket-issue handshake toward the ticket dispenser: it raises a ready pulse and waits for the dispenser's completion pulse. After completion it pays back any surplus as change pulses. It also handles customer cancel and refund.

---
 rtl/fare_pkg.sv | 32 +++
 rtl/fare_ctrl_unit_pulser.sv | 46 ++++
 rtl/fare_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_fare_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fare_pkg.sv
// fare_pkg: shared constants for the fare controller.
// State codes, coin values and the change-pulse phase encoding.
package fare_pkg;

  // Controller states, kept as plain codes so older tools and dumps read them directly.
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_COLLECT   = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_CHANGE    = 3'd4;
  localparam logic [2:0] S_REFUND    = 3'd5;

  // Coin denominations in fare units.
  localparam int unsigned COIN_1_VAL = 1;
  localparam int unsigned COIN_2_VAL = 2;
  localparam int unsigned COIN_5_VAL = 5;

  // One returned unit is one high cycle followed by one low cycle.
  localparam logic PULSE_HI = 1'b1;
  localparam logic PULSE_LO = 1'b0;

  // Value of all coins arriving in one cycle; worst case 1+2+5 = 8.
  function automatic logic [3:0] coin_sum(input logic c1, input logic c2, input logic c5);
    logic [3:0] s;
    s = 4'd0;
    if (c1) s = s + 4'(COIN_1_VAL);
    if (c2) s = s + 4'(COIN_2_VAL);
    if (c5) s = s + 4'(COIN_5_VAL);
    return s;
  endfunction

endpackage

// File: rtl/fare_ctrl_unit_pulser.sv
// unit_pulser: plays out 'count' units as high/low pulse pairs.
// A load starts the first high cycle on the next clock; done is a
// strobe during the final low cycle so the owner can leave on that edge.
module unit_pulser
  import fare_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] count,
  output logic         pulse,
  output logic         done
);

  logic         active_q;
  logic         phase_q;
  logic [W-1:0] rem_q;   // units still to start after the current one

  // Pulse sequencer: high, low, high, low ... until the count is exhausted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= 1'b0;
      phase_q  <= PULSE_LO;
      rem_q    <= '0;
    end else if (load) begin
      active_q <= (count != '0);
      phase_q  <= (count != '0) ? PULSE_HI : PULSE_LO;
      rem_q    <= count - W'(1);
    end else if (active_q) begin
      if (phase_q == PULSE_HI) begin
        phase_q <= PULSE_LO;
      end else if (rem_q == '0) begin
        active_q <= 1'b0;
      end else begin
        phase_q <= PULSE_HI;
        rem_q   <= rem_q - W'(1);
      end
    end
  end

  assign pulse = (phase_q == PULSE_HI);
  assign done  = active_q && (phase_q == PULSE_LO) && (rem_q == '0);

endmodule

// File: rtl/fare_ctrl.sv
// fare_ctrl: payment-side controller of the ticket vending machine.
// Collects coins, hands one ticket request to the dispenser once the fare
// is covered, then pays surplus back as change pulses; cancel refunds.
// Optional: define FARE_TIMEOUT_EN to abort a dispenser that never
// completes (sticky fault, full refund, coins locked out until reset).
module fare_ctrl
  import fare_pkg::*;
#(
  parameter int FARE     = 9,
  parameter int CREDIT_W = 5,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_1,
  input  logic                coin_2,
  input  logic                coin_5,
  input  logic                cancel,
  input  logic                issue_done,
  output logic                rdy_issue,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                sale_done,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic                fault
);

  // Elaboration guards on parameter sanity.
  if ((FARE + 7) >= (1 << CREDIT_W)) begin : g_bad_width
    $error("CREDIT_W too narrow to hold FARE+7");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  logic [2:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                rej_q, rej_d;
  logic                sale_q, sale_d;

  logic                any_coin;
  logic [CREDIT_W:0]   credit_next;   // one extra bit so the fare compare never wraps
  logic                reach_fare;
  logic                coin_lock;
  logic                tmo_hit;

  logic                pl_load;
  logic [CREDIT_W-1:0] pl_cnt;
  logic                pl_pulse;
  logic                pl_done;

  assign any_coin    = coin_1 | coin_2 | coin_5;
  assign credit_next = {1'b0, credit_q} + (CREDIT_W+1)'(coin_sum(coin_1, coin_2, coin_5));
  assign reach_fare  = (credit_next >= (CREDIT_W+1)'(FARE));

`ifdef FARE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          fault_q;

  // Cycles spent in WAIT_DONE; restarts on every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        tmo_cnt <= '0;
    else if (state_q != S_WAIT_DONE) tmo_cnt <= '0;
    else                             tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Sticky dispenser fault; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         fault_q <= 1'b0;
    else if (tmo_hit && !issue_done)  fault_q <= 1'b1;
  end

  assign tmo_hit   = (state_q == S_WAIT_DONE) && (tmo_cnt == TW'(TIMEOUT - 1));
  assign coin_lock = fault_q;
  assign fault     = fault_q;
`else
  assign tmo_hit   = 1'b0;
  assign coin_lock = 1'b0;
  assign fault     = 1'b0;
`endif

  // Change and refund share one pulser; only one of them runs at a time.
  unit_pulser #(.W(CREDIT_W)) u_pulser (
    .clk   (clk),
    .rst   (rst),
    .load  (pl_load),
    .count (pl_cnt),
    .pulse (pl_pulse),
    .done  (pl_done)
  );

  // Next-state, credit bookkeeping and pulser control.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = change_q;
    rej_d    = 1'b0;
    sale_d   = 1'b0;
    pl_load  = 1'b0;
    pl_cnt   = credit_q;
    case (state_q)
      S_IDLE: begin
        // Cancel with nothing inserted has nothing to return.
        if (any_coin) begin
          if (coin_lock) begin
            rej_d = 1'b1;
          end else begin
            credit_d = credit_next[CREDIT_W-1:0];
            state_d  = reach_fare ? S_ISSUE : S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        // Coins arriving with the fare-reaching edge win over cancel.
        if (reach_fare) begin
          credit_d = credit_next[CREDIT_W-1:0];
          state_d  = S_ISSUE;
        end else if (cancel && (credit_q != '0)) begin
          rej_d   = any_coin;
          pl_load = 1'b1;
          pl_cnt  = credit_q;
          state_d = S_REFUND;
        end else begin
          credit_d = credit_next[CREDIT_W-1:0];
        end
      end
      S_ISSUE: begin
        rej_d    = any_coin;
        change_d = credit_q - CREDIT_W'(FARE);
        state_d  = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        rej_d = any_coin;
        if (issue_done) begin
          credit_d = '0;
          if (change_q != '0) begin
            pl_load = 1'b1;
            pl_cnt  = change_q;
            state_d = S_CHANGE;
          end else begin
            sale_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (tmo_hit) begin
          // Ticket never came out: give the whole credit back.
          pl_load = 1'b1;
          pl_cnt  = credit_q;
          state_d = S_REFUND;
        end
      end
      S_CHANGE: begin
        rej_d = any_coin;
        if (pl_done) begin
          sale_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_REFUND: begin
        rej_d = any_coin;
        // Credit tracks what is still owed: drop one unit per high cycle.
        if (pl_pulse) credit_d = credit_q - CREDIT_W'(1);
        if (pl_done)  state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      change_q <= '0;
      rej_q    <= 1'b0;
      sale_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      rej_q    <= rej_d;
      sale_q   <= sale_d;
    end
  end

  assign rdy_issue    = (state_q == S_ISSUE);
  assign busy         = (state_q != S_IDLE) && (state_q != S_COLLECT);
  assign change_pulse = pl_pulse;
  assign coin_reject  = rej_q;
  assign sale_done    = sale_q;
  assign credit       = credit_q;

endmodule

// File: tb/tb_fare_ctrl.sv
// tb_fare_ctrl: directed vector table, reset-in-flight sequence, and a
// randomized run against a transaction-style reference model.
module tb_fare_ctrl;

  localparam int FARE = 9;
  localparam int CW   = 5;
  localparam int TMO  = 255;
  localparam int OW   = CW + 6;

  typedef logic [OW-1:0] ovec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          coin_1 = 1'b0, coin_2 = 1'b0, coin_5 = 1'b0;
  logic          cancel = 1'b0, issue_done = 1'b0;
  logic          rdy_issue, change_pulse, coin_reject, sale_done, busy, fault;
  logic [CW-1:0] credit;

  fare_ctrl #(.FARE(FARE), .CREDIT_W(CW), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_1       (coin_1),
    .coin_2       (coin_2),
    .coin_5       (coin_5),
    .cancel       (cancel),
    .issue_done   (issue_done),
    .rdy_issue    (rdy_issue),
    .change_pulse (change_pulse),
    .coin_reject  (coin_reject),
    .sale_done    (sale_done),
    .busy         (busy),
    .credit       (credit),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic ovec_t pack(bit rdy, bit pls, bit rej, bit sale, bit bsy, bit flt, int cred);
    return {rdy, pls, rej, sale, bsy, flt, CW'(cred)};
  endfunction

  function automatic ovec_t dut_out();
    return {rdy_issue, change_pulse, coin_reject, sale_done, busy, fault, credit};
  endfunction

  // Vector layout: {rdy_issue, change_pulse, coin_reject, sale_done, busy, fault, credit}
  task automatic check_v(input string nm, input ovec_t act, input ovec_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic check_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Inputs are applied for exactly one clock; outputs are read 1 time unit after the edge.
  task automatic drive(input bit c1, input bit c2, input bit c5, input bit can, input bit dn);
    coin_1 = c1; coin_2 = c2; coin_5 = c5; cancel = can; issue_done = dn;
    @(posedge clk);
    #1;
    coin_1 = 1'b0; coin_2 = 1'b0; coin_5 = 1'b0; cancel = 1'b0; issue_done = 1'b0;
  endtask

  task automatic reset_dut();
    coin_1 = 1'b0; coin_2 = 1'b0; coin_5 = 1'b0; cancel = 1'b0; issue_done = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // Open = accepting coins; Drain = playing out a precomputed list of
  // per-cycle {pulse, credit} slots, followed by one closing cycle.
  typedef enum int {M_OPEN, M_ISSUE, M_WAIT, M_DRAIN} mmode_e;
  typedef struct { bit pls; int cred; } slot_t;

  mmode_e m_mode;
  int     m_credit, m_chg, m_wait;
  bit     m_fault, m_rej, m_sale, m_pls, m_drain_sale;
  slot_t  m_q[$];

  function automatic void m_reset();
    m_mode = M_OPEN; m_credit = 0; m_chg = 0; m_wait = 0;
    m_fault = 0; m_rej = 0; m_sale = 0; m_pls = 0; m_drain_sale = 0;
    m_q.delete();
  endfunction

  function automatic void m_pop();
    slot_t s;
    s = m_q.pop_front();
    m_pls = s.pls;
    m_credit = s.cred;
  endfunction

  // n units: 2n cycles; a refund shows the amount still owed.
  function automatic void m_fill(int n, bit refund);
    m_q.delete();
    for (int k = 1; k <= n; k++) begin
      m_q.push_back('{1'b1, refund ? n - k + 1 : 0});
      m_q.push_back('{1'b0, refund ? n - k : 0});
    end
    m_drain_sale = !refund;
    m_mode = M_DRAIN;
    m_pop();
  endfunction

  function automatic void m_step(bit c1, bit c2, bit c5, bit can, bit dn);
    int coins;
    bit any;
    coins = int'(c1) + 2 * int'(c2) + 5 * int'(c5);
    any = (coins != 0);
    m_rej = 0; m_sale = 0; m_pls = 0;
    case (m_mode)
      M_OPEN: begin
        if (m_fault) m_rej = any;
        else if (m_credit + coins >= FARE) begin m_credit += coins; m_mode = M_ISSUE; end
        else if (can && m_credit > 0) begin m_rej = any; m_fill(m_credit, 1'b1); end
        else m_credit += coins;
      end
      M_ISSUE: begin
        m_rej = any; m_chg = m_credit - FARE; m_wait = 0; m_mode = M_WAIT;
      end
      M_WAIT: begin
        m_rej = any;
        if (dn) begin
          m_credit = 0;
          if (m_chg > 0) m_fill(m_chg, 1'b0);
          else begin m_sale = 1; m_mode = M_OPEN; end
        end else begin
          m_wait++;
`ifdef FARE_TIMEOUT_EN
          if (m_wait == TMO) begin m_fault = 1; m_fill(m_credit, 1'b1); end
`endif
        end
      end
      M_DRAIN: begin
        m_rej = any;
        if (m_q.size() == 0) begin m_mode = M_OPEN; m_sale = m_drain_sale; end
        else m_pop();
      end
      default: m_mode = M_OPEN;
    endcase
  endfunction

  function automatic ovec_t m_exp();
    return pack(m_mode == M_ISSUE, m_pls, m_rej, m_sale, m_mode != M_OPEN, m_fault, m_credit);
  endfunction

  task automatic rstep(input bit c1, input bit c2, input bit c5, input bit can, input bit dn,
                       input string nm);
    drive(c1, c2, c5, can, dn);
    m_step(c1, c2, c5, can, dn);
    check_v(nm, dut_out(), m_exp());
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit c1, c2, c5, can, dn;
    bit rdy, pls, rej, sale, bsy;
    int cred;
  } vec_t;

  vec_t tv[$];

  function automatic void add(bit c1, bit c2, bit c5, bit can, bit dn,
                              bit rdy, bit pls, bit rej, bit sale, bit bsy, int cred);
    vec_t v;
    v.c1 = c1; v.c2 = c2; v.c5 = c5; v.can = can; v.dn = dn;
    v.rdy = rdy; v.pls = pls; v.rej = rej; v.sale = sale; v.bsy = bsy; v.cred = cred;
    tv.push_back(v);
  endfunction

  int npls;
  int f0;

  initial begin
    // inputs: c1 c2 c5 cancel done | expected: rdy pulse reject sale busy credit
    add(0,0,0,1,0, 0,0,0,0,0,0);    // cancel in IDLE ignored
    add(0,0,0,0,1, 0,0,0,0,0,0);    // stray issue_done ignored
    add(0,0,1,0,0, 0,0,0,0,0,5);    // 5, 5 -> ticket + 1 change
    add(0,0,1,0,0, 1,0,0,0,1,10);
    add(0,0,0,0,0, 0,0,0,0,1,10);
    add(1,0,0,0,0, 0,0,1,0,1,10);   // coin while waiting is rejected
    add(0,0,0,1,0, 0,0,0,0,1,10);   // cancel while waiting ignored
    add(0,0,0,0,1, 0,1,0,0,1,0);
    add(0,0,0,0,0, 0,0,0,0,1,0);
    add(0,0,0,0,0, 0,0,0,1,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    add(0,1,0,0,0, 0,0,0,0,0,2);    // 2, 2, 5 -> exact fare
    add(0,1,0,0,0, 0,0,0,0,0,4);
    add(0,0,1,0,0, 1,0,0,0,1,9);
    add(0,0,0,0,0, 0,0,0,0,1,9);
    add(0,0,0,0,1, 0,0,0,1,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    add(1,1,1,0,0, 0,0,0,0,0,8);    // all coins at once, then 1
    add(1,0,0,0,0, 1,0,0,0,1,9);
    add(0,0,0,0,1, 0,0,0,0,1,9);    // issue_done during ISSUE ignored
    add(0,0,0,0,1, 0,0,0,1,0,0);
    add(1,1,1,0,0, 0,0,0,0,0,8);
    add(0,1,0,0,0, 1,0,0,0,1,10);
    add(1,0,0,0,0, 0,0,1,0,1,10);   // coin during ISSUE rejected
    add(0,0,0,0,1, 0,1,0,0,1,0);
    add(0,1,0,0,0, 0,0,1,0,1,0);    // coin during CHANGE rejected
    add(0,0,0,0,0, 0,0,0,1,0,0);
    add(0,0,1,0,0, 0,0,0,0,0,5);    // 5, 2, cancel(+coin) -> refund 7
    add(0,1,0,0,0, 0,0,0,0,0,7);
    add(1,0,0,1,0, 0,1,1,0,1,7);
    for (int c = 2; c <= 14; c++) add(0,0,0,0,0, 0,c % 2,0,0,1,7 - c / 2);
    add(0,0,0,0,0, 0,0,0,0,0,0);    // back to IDLE, no sale_done
    add(1,0,0,0,0, 0,0,0,0,0,1);
    add(0,0,0,1,0, 0,1,0,0,1,1);    // refund of a single unit
    add(0,0,0,0,0, 0,0,0,0,1,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);

    reset_dut();
    check_v("reset", dut_out(), '0);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].c1, tv[i].c2, tv[i].c5, tv[i].can, tv[i].dn);
      check_v($sformatf("vec%0d", i), dut_out(),
              pack(tv[i].rdy, tv[i].pls, tv[i].rej, tv[i].sale, tv[i].bsy, 1'b0, tv[i].cred));
    end

    // Reset asserted while change is being paid out.
    reset_dut();
    drive(1,1,1,0,0); check_v("rm_c8",    dut_out(), pack(0,0,0,0,0,0,8));
    drive(1,1,1,0,0); check_v("rm_issue", dut_out(), pack(1,0,0,0,1,0,16));
    drive(0,0,0,0,0); check_v("rm_wait",  dut_out(), pack(0,0,0,0,1,0,16));
    drive(0,0,0,0,1); check_v("rm_chg1",  dut_out(), pack(0,1,0,0,1,0,0));
    drive(0,0,0,0,0);
    drive(0,0,0,0,0); check_v("rm_chg2",  dut_out(), pack(0,1,0,0,1,0,0));
    #2 rst = 1'b0;
    #1 check_v("rm_async", dut_out(), '0);
    @(posedge clk);
    #1 check_v("rm_hold", dut_out(), '0);
    rst = 1'b1;
    drive(0,0,0,0,0); check_v("rm_idle", dut_out(), '0);
    drive(1,0,0,0,0); check_v("rm_coin", dut_out(), pack(0,0,0,0,0,0,1));

    // Randomized traffic against the model.
    reset_dut();
    m_reset();
    f0 = failures;
    for (int i = 0; i < 4000 && (failures - f0) < 10; i++) begin
      bit c1, c2, c5, can, dn;
      c1  = ($urandom_range(0, 4) == 0);
      c2  = ($urandom_range(0, 4) == 0);
      c5  = ($urandom_range(0, 4) == 0);
      can = ($urandom_range(0, 11) == 0);
      dn  = ($urandom_range(0, 4) == 0);
      rstep(c1, c2, c5, can, dn, "rand");
    end

`ifdef FARE_TIMEOUT_EN
    // Dispenser never answers: fault, full refund, coins locked out.
    reset_dut();
    m_reset();
    rstep(0,0,1,0,0, "tmo_c5a");
    rstep(0,0,1,0,0, "tmo_c5b");
    npls = 0;
    for (int i = 0; i < TMO + 40; i++) begin
      rstep(0,0,0,0,0, "tmo_run");
      if (change_pulse) npls++;
    end
    check_i("tmo_fault",   int'(fault), 1);
    check_i("tmo_pulses",  npls, 10);
    check_i("tmo_credit",  int'(credit), 0);
    rstep(1,0,0,0,0, "tmo_lock");
    check_i("tmo_lock_rej", int'(coin_reject), 1);
    reset_dut();
    check_i("tmo_clear", int'(fault), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
